// File: rtl/alu_iter.sv
// alu_iter: registered RV32 ALU; single-cycle integer ops plus iterative MUL/MULHU/DIVU/REMU.
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d, result_q, result_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic zero_q, zero_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] alu, rsub;
  logic [WIDTH:0] acc, rsh;
  logic [SW-1:0] sh;
  logic iter, geq, last;
  always_comb begin
    sh = b[SW-1:0];
    alu = '0;
    case (ALUControl)
      4'b0000: alu = a & b;
      4'b0001: alu = a | b;
      4'b0010: alu = a + b;
      4'b0011: alu = a << sh;
      4'b0100: alu = a ^ b;
      4'b0101: alu = a >> sh;
      4'b0110: alu = a - b;
      4'b0111: alu = $signed(a) >>> sh;
      4'b1000: alu = WIDTH'($signed(a) < $signed(b));
      4'b1001: alu = WIDTH'(a < b);
      default: alu = '0;
    endcase
  end
  // 1010..1101 are the iterative opcodes
  assign iter = ALUControl[3] & (ALUControl[2] ^ ALUControl[1]);
  assign acc  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign rsh  = {rem_q, quo_q[WIDTH-1]};
  assign geq  = rsh >= {1'b0, b_q};
  assign rsub = rsh[WIDTH-1:0] - b_q;
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start && iter) begin
        a_d     = a;
        b_d     = b;
        op_d    = ALUControl;
        cnt_d   = '0;
        prod_d  = {{WIDTH{1'b0}}, b};
        quo_d   = a;
        rem_d   = '0;
        state_d = ALUControl[2] ? DIV : MUL;
      end else if (start) begin
        result_d = alu;
        done_d   = 1'b1;
      end
      MUL: begin
        prod_d  = prod_q[0] ? {acc, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last ? FIN : MUL;
      end
      DIV: begin
        rem_d   = geq ? rsub : rsh[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], geq};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = last ? FIN : DIV;
      end
      default: begin
        result_d = op_q[2] ? (op_q[0] ? (b_q == '0 ? a_q : rem_q) : (b_q == '0 ? '1 : quo_q))
                           : (op_q[0] ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0]);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    endcase
    zero_d = result_d == '0;
    busy_d = state_d == MUL || state_d == DIV;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter at WIDTH = 32.
module tb_alu_iter;
  logic clk, rst, start, zero, busy, done;
  logic [31:0] a, b, result;
  logic [3:0] ALUControl;
  int n_tests, n_fail;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t q[$];

  alu_iter dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ALUControl(ALUControl),
                .result(result), .zero(zero), .busy(busy), .done(done));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && done) begin
      if (q.size() == 0) chk("spurious_done", done, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk(e.tag, result, e.v);
        chk({e.tag, "_zero"}, zero, e.v == 0);
      end
    end

  task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ev, input string tag, input bit push);
    ALUControl = op;
    a = x;
    b = y;
    start = 1;
    if (push) q.push_back('{tag, ev});
    @(negedge clk);
    start = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int n, bc, hc;
    logic [31:0] x, y;
    logic [63:0] p;
    n_tests = 0;
    n_fail = 0;
    rst = 1;
    start = 0;
    a = 0;
    b = 0;
    ALUControl = 0;
    repeat (3) begin
      @(negedge clk);
      start = 1;
      a = $urandom;
      b = $urandom;
      ALUControl = 4'($urandom);
    end
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    start = 0;
    @(negedge clk);
    drive(4'b0010, 5, 7, 12, "add", 1);
    chk("add_done_lat", done, 1);
    drain();

    drive(4'b0110, 3, 5, 32'hFFFFFFFE, "sub", 1);
    drive(4'b0111, 32'h80000000, 4, 32'hF8000000, "sra", 1);
    drive(4'b1000, 32'hFFFFFFFF, 1, 1, "slt", 1);
    drive(4'b1001, 32'hFFFFFFFF, 1, 0, "sltu", 1);
    drive(4'b0100, 32'h5A5A1234, 32'h5A5A1234, 0, "xor", 1);
    drive(4'b0000, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, "and", 1);
    drive(4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, "or", 1);
    drive(4'b0011, 32'h00000003, 32'h00000024, 32'h00000030, "sll", 1);
    drive(4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001, "srl", 1);
    drive(4'b1110, 32'h12345678, 32'h1, 0, "undef", 1);
    drain();

    drive(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul", 1);
    bc = 0;
    n = 1;
    while (!done && n < 60) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    chk("mul_latency", n, 34);
    chk("busy_cycles", bc, 32);
    drain();
    drive(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu", 1);
    drain();

    drive(4'b1100, 100, 7, 14, "divu", 1);
    repeat (10) begin
      a = $urandom;
      b = $urandom;
      ALUControl = 4'b0010;
      start = ~start;
      @(negedge clk);
    end
    start = 0;
    drain();
    drive(4'b1101, 100, 7, 2, "remu", 1);
    drain();
    drive(4'b1100, 5, 0, 32'hFFFFFFFF, "divu_by0", 1);
    drain();
    drive(4'b1101, 32'h1234, 0, 32'h1234, "remu_by0", 1);
    drain();

    repeat (3) begin
      x = $urandom;
      y = $urandom;
      p = {32'b0, x} * {32'b0, y};
      drive(4'b1010, x, y, p[31:0], "mul_rnd", 1);
      drain();
      drive(4'b1011, x, y, p[63:32], "mulhu_rnd", 1);
      drain();
      y = (y >> $urandom_range(0, 28)) | 32'd1;
      drive(4'b1100, x, y, x / y, "divu_rnd", 1);
      drain();
      drive(4'b1101, x, y, x % y, "remu_rnd", 1);
      drain();
    end

    drive(4'b1101, 32'h1234, 0, 32'h1234, "remu_pre_rst", 1);
    drain();
    drive(4'b1100, 32'hDEADBEEF, 3, 0, "divu_abort", 0);
    repeat (9) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    drive(4'b1010, 6, 7, 42, "mul_after_rst", 1);
    drain();

    drive(4'b1010, 3, 4, 12, "b2b_mul", 1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    drive(4'b0010, 1, 1, 2, "b2b_add", 1);
    chk("b2b_done", done, 1);
    drain();

    hc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0010, i, 100, i + 100, "stream_add", 1);
      hc += int'(done);
    end
    chk("stream_len", hc, 10);
    @(negedge clk);
    chk("stream_end", done, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised registered ALU for the RISC-V datapath, with RV32M-style multiply and unsigned divide. Single-cycle integer ops (add, sub, logic, shifts, compares) return with one cycle of latency. MUL, MULHU, DIVU and REMU run as iterative shift-add / restoring-divide sequences behind a start/busy/done handshake. The block sits in the execute stage; the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width. Must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)+1`: iteration counter width. Derived; do not override.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: launch an operation. Sampled only when not `busy`.
- `a` in WIDTH: operand A. Latched on an accepted `start`.
- `b` in WIDTH: operand B. Latched on an accepted `start`.
- `ALUControl` in 4: operation code. Latched on an accepted `start`.
- `result` out WIDTH: registered result. Holds until the next `done`.
- `zero` out 1: registered flag, high when `result` == 0.
- `busy` out 1: high while an iterative op is in progress.
- `done` out 1: one-cycle pulse when `result` is updated.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 XOR, 0101 SRL, 0110 SUB, 0111 SRA.
  - 1000 SLT (signed, result 0/1), 1001 SLTU (result 0/1).
  - 1010 MUL (low WIDTH bits of the unsigned product), 1011 MULHU (high WIDTH bits).
  - 1100 DIVU, 1101 REMU.
  - 1110 and 1111: undefined; result = 0, completes as a single-cycle op.
- Shift amount = `b[$clog2(WIDTH)-1:0]`. Add and sub wrap modulo 2^WIDTH. Operands are treated as unsigned except for SLT and SRA.
- FSM states and transitions:
  - IDLE: accepts `start`. Single-cycle opcodes compute combinationally from the live inputs and load `result` directly, staying in IDLE. Iterative opcodes latch the operands, clear the accumulator and counter, then go to MUL or DIV.
  - MUL: one shift-add step per cycle over `b`'s bits, with a 2·WIDTH product register. After WIDTH steps, go to FIN.
  - DIV: one restoring step per cycle, with quotient and remainder registers. After WIDTH steps, go to FIN.
  - FIN: load `result` from the op-selected half (product low/high, quotient or remainder). Pulse `done`, return to IDLE.
- Divide by zero runs the normal WIDTH steps, then forces DIVU = all ones and REMU = latched `a`. No exception is raised.
- `start` while `busy` is ignored. No queueing, no error.
- `zero` is updated in the same edge as `result`.

## Timing
- Reset values: `result` = 0, `zero` = 1, `busy` = 0, `done` = 0. FSM in IDLE, counter 0, internal registers 0.
- Single-cycle op: `start` sampled high at edge k → `result`, `zero` valid and `done` = 1 after edge k; `done` low after edge k+1 unless restarted.
- Iterative op: `start` sampled at edge k.
  - `busy` = 1 after edges k .. k+WIDTH-1.
  - FIN is entered after edge k+WIDTH; `busy` = 0 in FIN.
  - `result`, `zero` and `done` update after edge k+WIDTH+1. Latency is WIDTH+2 cycles from `start` to `done`.
- Back-to-back: `start` high in the cycle where `done` = 1 (FSM in IDLE) is accepted. Single-cycle ops may issue every cycle, with `done` held high continuously.
- Changes to `a`, `b`, `ALUControl` during `busy` have no effect on the running op.
- `rst` mid-operation: immediate return to reset values. The op is abandoned with no `done`. The next `start` after `rst` deasserts behaves normally.

## Test plan
(WIDTH = 32 throughout.)
- Reset: hold `rst` with random inputs → `result` = 0, `zero` = 1, `busy` = 0, `done` = 0. Release, issue ADD 5+7 → `result` = 12, `done` one cycle after `start`.
- Single-cycle sweep: SUB 3−5 → 0xFFFFFFFE; SRA 0x80000000>>4 → 0xF8000000; SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0; XOR equal operands → 0 with `zero` = 1.
- MUL/MULHU 0xFFFFFFFF×0xFFFFFFFF → low 0x00000001, high 0xFFFFFFFE. Check `busy` high exactly 32 cycles and `done` exactly 34 cycles after `start`.
- DIVU 100/7 → 14, REMU → 2. DIVU x/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234. Toggle `a`/`b`/`start` during `busy` → result unchanged, second start ignored.
- Assert `rst` at iteration 10 of a DIVU → outputs return to reset values at once, no `done`. Then MUL 6×7 → 42.
- Back-to-back: `start` in the `done` cycle of MUL 3×4 with ADD 1+1 → 12 then 2 on consecutive `done` pulses. Ten consecutive ADDs → `done` held high for 10 cycles.
